// File: rtl/ascon_pkg.sv
// Shared Ascon constants, sequencer state encoding and the round-constant function.
package ascon_pkg;

  localparam int unsigned ASCON_MAX_ROUNDS = 12;
  localparam int unsigned ASCON_RC_W       = 8;
  localparam int unsigned ASCON_PA         = 12;
  localparam int unsigned ASCON_PB         = 6;
  localparam int unsigned ASCON_IDX_W      = 5;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_DONE = ST_DONE_ENC
  } rc_state_t;

  // {~i, i} equals 0xF0 - 15*i for every 4-bit i.
  function automatic logic [ASCON_RC_W-1:0] ascon_rc(input logic [3:0] idx);
    return {~idx, idx};
  endfunction

endpackage

// File: rtl/ascon_rc_sequencer_if.sv
// Handshake between the mode controller (master) and the round-constant sequencer (slave).
interface ascon_rc_sequencer_if
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
);

  logic                           start;
  logic [3:0]                     rounds;
  logic                           stall;
  logic                           abort;
  logic                           ready;
  logic                           busy;
  logic [UNROLL*ASCON_RC_W-1:0]   rc_out;
  logic [UNROLL-1:0]              rc_valid;
  logic                           step_valid;
  logic                           first;
  logic                           last;
  logic                           done;
  logic                           err;

  modport master (
    output start, rounds, stall, abort,
    input  ready, busy, rc_out, rc_valid, step_valid, first, last, done, err
  );

  modport slave (
    input  start, rounds, stall, abort,
    output ready, busy, rc_out, rc_valid, step_valid, first, last, done, err
  );

endinterface

// File: rtl/ascon_rc_lane.sv
// One lane of the constant generator: constant and validity for a 5-bit round index.
module ascon_rc_lane
  import ascon_pkg::*;
(
  input  logic [ASCON_IDX_W-1:0] i_idx,
  output logic [ASCON_RC_W-1:0]  o_rc,
  output logic                   o_valid
);

  logic w_in_range;

  assign w_in_range = (i_idx <= ASCON_IDX_W'(ASCON_MAX_ROUNDS - 1));
  assign o_valid    = w_in_range;
  assign o_rc       = w_in_range ? ascon_rc(i_idx[3:0]) : '0;

endmodule

// File: rtl/ascon_rc_sequencer.sv
// Streams Ascon round constants, UNROLL per step, for a requested round count.
module ascon_rc_sequencer
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL     = 1,
  parameter int unsigned MAX_ROUNDS = 12,
  parameter int unsigned RC_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ascon_rc_sequencer_if.slave  bus
);

  localparam int unsigned IDX_W = ASCON_IDX_W;

  rc_state_t               r_state;
  logic [3:0]              r_idx;
  logic                    r_ready;
  logic                    r_busy;
  logic [UNROLL*RC_W-1:0]  r_rc_out;
  logic [UNROLL-1:0]       r_rc_valid;
  logic                    r_step_valid;
  logic                    r_first;
  logic                    r_last;
  logic                    r_done;
  logic                    r_err;

  logic                    w_legal;
  logic [IDX_W-1:0]        w_nidx;
  logic                    w_nlast;
  logic [IDX_W-1:0]        w_lane_idx [UNROLL];
  logic [RC_W-1:0]         w_lane_rc  [UNROLL];
  logic [UNROLL-1:0]       w_lane_vld;
  logic [UNROLL*RC_W-1:0]  w_rc_pack;

  assign w_legal = (bus.rounds != 4'd0) && (IDX_W'(bus.rounds) <= IDX_W'(MAX_ROUNDS));

  // Index of the step that would be presented after this edge.
  always_comb begin
    w_nidx = IDX_W'(r_idx);
    case (r_state)
      ST_IDLE: w_nidx = IDX_W'(MAX_ROUNDS) - IDX_W'(bus.rounds);
      ST_RUN:  if (!bus.stall) w_nidx = IDX_W'(r_idx) + IDX_W'(UNROLL);
      default: w_nidx = IDX_W'(r_idx);
    endcase
  end

  assign w_nlast = ((w_nidx + IDX_W'(UNROLL)) >= IDX_W'(MAX_ROUNDS));

  for (genvar j = 0; j < UNROLL; j++) begin : g_lane
    assign w_lane_idx[j] = w_nidx + IDX_W'(j);

    ascon_rc_lane u_lane (
      .i_idx   (w_lane_idx[j]),
      .o_rc    (w_lane_rc[j]),
      .o_valid (w_lane_vld[j])
    );
  end

  always_comb begin
    w_rc_pack = '0;
    for (int j = 0; j < UNROLL; j++) begin
      w_rc_pack[j*RC_W +: RC_W] = w_lane_rc[j];
    end
  end

  // Sequencer FSM with registered outputs; abort outranks start and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_rc_out     <= '0;
      r_rc_valid   <= '0;
      r_step_valid <= 1'b0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (bus.start) begin
            if (w_legal) begin
              r_state      <= ST_RUN;
              r_idx        <= w_nidx[3:0];
              r_ready      <= 1'b0;
              r_busy       <= 1'b1;
              r_rc_out     <= w_rc_pack;
              r_rc_valid   <= w_lane_vld;
              r_step_valid <= 1'b1;
              r_first      <= 1'b1;
              r_last       <= w_nlast;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (bus.abort) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_rc_out     <= '0;
            r_rc_valid   <= '0;
            r_step_valid <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
          end else if (!bus.stall) begin
            if (r_last) begin
              r_state      <= ST_DONE;
              r_idx        <= '0;
              r_busy       <= 1'b0;
              r_rc_out     <= '0;
              r_rc_valid   <= '0;
              r_step_valid <= 1'b0;
              r_first      <= 1'b0;
              r_last       <= 1'b0;
              r_done       <= 1'b1;
            end else begin
              r_idx      <= w_nidx[3:0];
              r_rc_out   <= w_rc_pack;
              r_rc_valid <= w_lane_vld;
              r_first    <= 1'b0;
              r_last     <= w_nlast;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready      = r_ready;
  assign bus.busy       = r_busy;
  assign bus.rc_out     = r_rc_out;
  assign bus.rc_valid   = r_rc_valid;
  assign bus.step_valid = r_step_valid;
  assign bus.first      = r_first;
  assign bus.last       = r_last;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_ascon_rc_sequencer.sv
// Drives UNROLL=1 and UNROLL=4 sequencers with shared stimulus against a step-list model.
module tb_ascon_rc_sequencer;

  logic clk;
  logic rst;
  logic tb_start;
  logic [3:0] tb_rounds;
  logic tb_stall;
  logic tb_abort;

  int n_checks = 0;
  int n_fail   = 0;

  ascon_rc_sequencer_if #(.UNROLL(1)) bus1 ();
  ascon_rc_sequencer_if #(.UNROLL(4)) bus4 ();

  assign bus1.start  = tb_start;
  assign bus1.rounds = tb_rounds;
  assign bus1.stall  = tb_stall;
  assign bus1.abort  = tb_abort;
  assign bus4.start  = tb_start;
  assign bus4.rounds = tb_rounds;
  assign bus4.stall  = tb_stall;
  assign bus4.abort  = tb_abort;

  ascon_rc_sequencer #(.UNROLL(1), .MAX_ROUNDS(12), .RC_W(8)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  ascon_rc_sequencer #(.UNROLL(4), .MAX_ROUNDS(12), .RC_W(8)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0=idle 1=run 2=done; a run is nsteps steps starting at round base.
  int unroll_of [2] = '{1, 4};
  int m_mode    [2];
  int m_base    [2];
  int m_pos     [2];
  int m_nsteps  [2];
  bit m_done    [2];
  bit m_err     [2];

  logic [7:0] seq12 [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                             8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit st, input int rnd, input bit stl,
                            input bit abt, input bit rs);
    int u;
    u = unroll_of[k];
    m_done[k] = 1'b0;
    m_err[k]  = 1'b0;
    if (rs) begin
      m_mode[k] = 0;
    end else begin
      case (m_mode[k])
        0: if (!abt && st) begin
             if (rnd >= 1 && rnd <= 12) begin
               m_mode[k]   = 1;
               m_base[k]   = 12 - rnd;
               m_pos[k]    = 0;
               m_nsteps[k] = (rnd + u - 1) / u;
             end else begin
               m_err[k] = 1'b1;
             end
           end
        1: if (abt) m_mode[k] = 0;
           else if (!stl) begin
             if (m_pos[k] == m_nsteps[k] - 1) begin
               m_mode[k] = 2;
               m_done[k] = 1'b1;
             end else begin
               m_pos[k]++;
             end
           end
        default: m_mode[k] = 0;
      endcase
    end
  endtask

  function automatic logic [63:0] exp_rc(input int k);
    logic [63:0] v;
    int i;
    v = '0;
    if (m_mode[k] == 1)
      for (int j = 0; j < unroll_of[k]; j++) begin
        i = m_base[k] + m_pos[k] * unroll_of[k] + j;
        if (i <= 11) v[j*8 +: 8] = 8'(240 - 15 * i);
      end
    return v;
  endfunction

  function automatic logic [63:0] exp_vld(input int k);
    logic [63:0] v;
    v = '0;
    if (m_mode[k] == 1)
      for (int j = 0; j < unroll_of[k]; j++)
        if (m_base[k] + m_pos[k] * unroll_of[k] + j <= 11) v[j] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] exp_flags(input int k);
    bit run;
    run = (m_mode[k] == 1);
    return 64'({m_mode[k] == 0, run, run, run && m_pos[k] == 0,
                run && m_pos[k] == m_nsteps[k] - 1, m_done[k], m_err[k]});
  endfunction

  task automatic check_all();
    check_eq("u1_flags", 64'({bus1.ready, bus1.busy, bus1.step_valid, bus1.first,
                              bus1.last, bus1.done, bus1.err}), exp_flags(0));
    check_eq("u1_rc",    64'(bus1.rc_out),   exp_rc(0));
    check_eq("u1_vld",   64'(bus1.rc_valid), exp_vld(0));
    check_eq("u4_flags", 64'({bus4.ready, bus4.busy, bus4.step_valid, bus4.first,
                              bus4.last, bus4.done, bus4.err}), exp_flags(1));
    check_eq("u4_rc",    64'(bus4.rc_out),   exp_rc(1));
    check_eq("u4_vld",   64'(bus4.rc_valid), exp_vld(1));
  endtask

  task automatic do_cycle(input bit st, input int rnd, input bit stl, input bit abt,
                          input bit rs);
    tb_start  = st;
    tb_rounds = 4'(rnd);
    tb_stall  = stl;
    tb_abort  = abt;
    rst       = rs;
    model_step(0, st, rnd, stl, abt, rs);
    model_step(1, st, rnd, stl, abt, rs);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) do_cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tb_start = 1'b0; tb_rounds = '0; tb_stall = 1'b0; tb_abort = 1'b0; rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_base[k] = 0; m_pos[k] = 0; m_nsteps[k] = 1;
      m_done[k] = 1'b0; m_err[k] = 1'b0;
    end
    do_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    do_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check_eq("reset_ready", 64'(bus1.ready), 64'd1);
    idle(2);

    // pa: full 12-constant stream
    do_cycle(1'b1, 12, 1'b0, 1'b0, 1'b0);
    check_eq("tp1_first", 64'(bus1.first), 64'd1);
    for (int s = 0; s < 12; s++) begin
      check_eq("tp1_rc", 64'(bus1.rc_out), 64'(seq12[s]));
      idle(1);
    end
    check_eq("tp1_done", 64'(bus1.done), 64'd1);
    idle(1);
    check_eq("tp1_ready", 64'(bus1.ready), 64'd1);

    // pb = 6 then 8
    do_cycle(1'b1, 6, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 6; s++) begin
      check_eq("tp2_rc6", 64'(bus1.rc_out), 64'(seq12[6 + s]));
      idle(1);
    end
    check_eq("tp2_done6", 64'(bus1.done), 64'd1);
    idle(1);
    do_cycle(1'b1, 8, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 8; s++) begin
      check_eq("tp2_rc8", 64'(bus1.rc_out), 64'(seq12[4 + s]));
      idle(1);
    end
    idle(2);

    // UNROLL=4 with a partial final step
    do_cycle(1'b1, 6, 1'b0, 1'b0, 1'b0);
    check_eq("tp3_rc_s1",  64'(bus4.rc_out),   64'h69788796);
    check_eq("tp3_vld_s1", 64'(bus4.rc_valid), 64'hF);
    idle(1);
    check_eq("tp3_rc_s2",  64'(bus4.rc_out),   64'h00004B5A);
    check_eq("tp3_vld_s2", 64'(bus4.rc_valid), 64'h3);
    check_eq("tp3_last",   64'(bus4.last),     64'd1);
    idle(1);
    check_eq("tp3_done",   64'(bus4.done),     64'd1);
    idle(6);

    // illegal round counts, then start while running
    do_cycle(1'b1, 0, 1'b0, 1'b0, 1'b0);
    check_eq("tp4_err0", 64'(bus1.err), 64'd1);
    do_cycle(1'b1, 13, 1'b0, 1'b0, 1'b0);
    check_eq("tp4_err13", 64'(bus4.err), 64'd1);
    idle(1);
    do_cycle(1'b1, 12, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 3, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 15, 1'b0, 1'b0, 1'b0);
    idle(12);

    // stall on C3 for three cycles, later abort on A5
    do_cycle(1'b1, 12, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("tp5_c3", 64'(bus1.rc_out), 64'hC3);
    for (int c = 0; c < 3; c++) do_cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check_eq("tp5_c3_held", 64'(bus1.rc_out), 64'hC3);
    idle(2);
    check_eq("tp5_a5", 64'(bus1.rc_out), 64'hA5);
    do_cycle(1'b1, 12, 1'b1, 1'b1, 1'b0);
    check_eq("tp5_abort_ready", 64'(bus1.ready), 64'd1);
    idle(3);

    // reset mid-sequence, then a fresh pa
    do_cycle(1'b1, 12, 1'b0, 1'b0, 1'b0);
    idle(7);
    check_eq("tp6_87", 64'(bus1.rc_out), 64'h87);
    do_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    do_cycle(1'b1, 12, 1'b0, 1'b0, 1'b0);
    check_eq("tp6_f0", 64'(bus1.rc_out), 64'hF0);
    idle(14);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      do_cycle($urandom_range(0, 99) < 30, int'($urandom_range(0, 15)),
               $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3,
               $urandom_range(0, 199) < 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
